// File: rtl/uart_port_arbiter.sv
// Shares one host UART link among four target UART ports.
// Auto mode locks the link to the first port showing a start bit and releases
// it after both routed lines stay idle; manual mode follows man_sel, switching
// only on an idle link.
module uart_port_arbiter #(
    parameter int unsigned IDLE_CYCLES = 64,
    parameter int unsigned HB_BIT      = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       host_rx,
    input  logic [3:0] tgt_rx,
    input  logic       auto_en,
    input  logic [1:0] man_sel,
    output logic       host_tx,
    output logic [3:0] tgt_tx,
    output logic [1:0] grant,
    output logic       busy,
    output logic       led_hb
);

    localparam int unsigned NUM_TGT = 4;
    localparam int unsigned CNT_W   = $clog2(IDLE_CYCLES + 1);
    localparam int unsigned HB_W    = HB_BIT + 1;
    localparam int unsigned SYNC_W  = NUM_TGT + 1;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IDLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_REL = CNT_W'(IDLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCK   = 2'd1,
        ST_MANUAL = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [1:0]         grant_next;
    logic [1:0]         last_grant, last_grant_next;
    logic [CNT_W-1:0]   idle_cnt, idle_cnt_next;
    logic [SYNC_W-1:0]  sync_q1, sync_q2;
    logic               s_host;
    logic [3:0]         s_tgt;
    logic               line_idle;
    logic               win_found;
    logic [1:0]         win_idx;
    logic [1:0]         cand;
    logic               host_tx_next;
    logic [3:0]         tgt_tx_next;
    logic               busy_next;
    logic [HB_W-1:0]    hb_cnt, hb_cnt_next;

    // Two-flop synchronizers on all rx pins; idle-high on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= '1;
            sync_q2 <= '1;
        end else begin
            sync_q1 <= {host_rx, tgt_rx};
            sync_q2 <= sync_q1;
        end
    end

    assign s_host = sync_q2[SYNC_W-1];
    assign s_tgt  = sync_q2[NUM_TGT-1:0];

    // Round-robin search for a start bit, beginning after last_grant
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_grant;
        cand      = last_grant;
        for (int k = 1; k <= NUM_TGT; k++) begin
            cand = last_grant + 2'(k);
            if (!win_found && !s_tgt[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state, grant, idle counter and routed line values
    always_comb begin
        state_next      = state;
        grant_next      = grant;
        last_grant_next = last_grant;
        host_tx_next    = 1'b1;
        tgt_tx_next     = 4'hF;

        line_idle = s_host & s_tgt[grant];
        if (!line_idle) begin
            idle_cnt_next = '0;
        end else if (idle_cnt == CNT_MAX) begin
            idle_cnt_next = idle_cnt;
        end else begin
            idle_cnt_next = idle_cnt + CNT_W'(1);
        end

        case (state)
            ST_IDLE: begin
                if (auto_en) begin
                    if (win_found) begin
                        grant_next      = win_idx;
                        last_grant_next = win_idx;
                        idle_cnt_next   = '0;
                        state_next      = ST_LOCK;
                    end else if (!s_host) begin
                        grant_next = last_grant;
                        state_next = ST_LOCK;
                    end
                end else begin
                    grant_next    = man_sel;
                    idle_cnt_next = CNT_MAX;
                    state_next    = ST_MANUAL;
                end
            end
            ST_LOCK: begin
                if (idle_cnt >= CNT_REL && line_idle) begin
                    state_next = ST_IDLE;
                end
            end
            ST_MANUAL: begin
                if (idle_cnt == CNT_MAX) begin
                    if (man_sel != grant) begin
                        grant_next    = man_sel;
                        idle_cnt_next = '0;
                    end
                    if (auto_en) begin
                        last_grant_next = grant;
                        state_next      = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Route with the grant that will be in effect so the start bit is kept
        if (state_next != ST_IDLE) begin
            host_tx_next            = s_tgt[grant_next];
            tgt_tx_next[grant_next] = s_host;
        end

        busy_next = (state_next == ST_LOCK);
    end

    // Arbiter state and registered routing outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            grant      <= 2'd0;
            last_grant <= 2'd3;
            idle_cnt   <= '0;
            host_tx    <= 1'b1;
            tgt_tx     <= 4'hF;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            grant      <= grant_next;
            last_grant <= last_grant_next;
            idle_cnt   <= idle_cnt_next;
            host_tx    <= host_tx_next;
            tgt_tx     <= tgt_tx_next;
            busy       <= busy_next;
        end
    end

    assign hb_cnt_next = hb_cnt + HB_W'(1);

    // Free-running heartbeat counter driving the blink LED
    always_ff @(posedge clk) begin
        if (rst) begin
            hb_cnt <= '0;
            led_hb <= 1'b0;
        end else begin
            hb_cnt <= hb_cnt_next;
            led_hb <= hb_cnt_next[HB_BIT];
        end
    end

endmodule

// File: tb/tb_uart_port_arbiter.sv
// Directed bench for uart_port_arbiter: grant/release, round-robin, host start,
// lock protection, mid-frame reset, manual switching and heartbeat period.
module tb_uart_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       host_rx;
    logic [3:0] tgt_rx;
    logic       auto_en;
    logic [1:0] man_sel;
    logic       host_tx;
    logic [3:0] tgt_tx;
    logic [1:0] grant;
    logic       busy;
    logic       led_hb;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] hist_t[$];
    logic       hist_h[$];

    typedef struct {
        string      name;
        logic [3:0] tgt_lo;
        logic       host_lo;
        logic [1:0] exp_grant;
    } vec_t;

    vec_t tbl[5];

    uart_port_arbiter #(
        .IDLE_CYCLES(64),
        .HB_BIT     (12)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .host_rx(host_rx),
        .tgt_rx (tgt_rx),
        .auto_en(auto_en),
        .man_sel(man_sel),
        .host_tx(host_tx),
        .tgt_tx (tgt_tx),
        .grant  (grant),
        .busy   (busy),
        .led_hb (led_hb)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Seed the pin history with the current (stable) pin values
    task automatic hist_reset();
        hist_t.delete();
        hist_h.delete();
        repeat (2) begin
            hist_t.push_back(tgt_rx);
            hist_h.push_back(host_rx);
        end
    endtask

    // Drive one cycle of pins, then compare outputs against pins delayed 3 edges
    task automatic lock_step(input logic [3:0] t, input logic h, input logic routed,
                             input logic exp_busy, input logic [1:0] g,
                             input logic chk_grant, input string tag);
        logic [3:0] dt;
        logic       dh;
        logic       exp_h;
        logic [3:0] exp_t;
        tgt_rx  = t;
        host_rx = h;
        hist_t.push_back(t);
        hist_h.push_back(h);
        dt = hist_t.pop_front();
        dh = hist_h.pop_front();
        step();
        exp_h = 1'b1;
        exp_t = 4'hF;
        if (routed) begin
            exp_h    = dt[g];
            exp_t[g] = dh;
        end
        check({tag, "_host_tx"}, host_tx, exp_h);
        check({tag, "_tgt_tx"}, tgt_tx, exp_t);
        check({tag, "_busy"}, busy, exp_busy);
        if (chk_grant) check({tag, "_grant"}, grant, g);
    endtask

    // Hold the listed lines low for 8 cycles, then release and wait for unlock
    task automatic run_vec(input vec_t v);
        logic act_on;
        hist_reset();
        for (int i = 0; i < 76; i++) begin
            act_on = (i >= 2 && i <= 72);
            lock_step((i < 8) ? ~v.tgt_lo : 4'hF, (i < 8) ? ~v.host_lo : 1'b1,
                      act_on, act_on, v.exp_grant, (i >= 2), v.name);
        end
    endtask

    initial begin
        logic [7:0] frame;
        logic [3:0] t;
        logic       act_on;
        logic       prev;
        int         cnt;
        int         b;

        tbl[0] = '{name: "host_only", tgt_lo: 4'b0000, host_lo: 1'b1, exp_grant: 2'd2};
        tbl[1] = '{name: "rr_0_3_a",  tgt_lo: 4'b1001, host_lo: 1'b0, exp_grant: 2'd3};
        tbl[2] = '{name: "rr_0_3_b",  tgt_lo: 4'b1001, host_lo: 1'b0, exp_grant: 2'd0};
        tbl[3] = '{name: "host_tgt1", tgt_lo: 4'b0010, host_lo: 1'b1, exp_grant: 2'd1};
        tbl[4] = '{name: "all_four",  tgt_lo: 4'b1111, host_lo: 1'b0, exp_grant: 2'd2};

        // Reset with arbitrary (active) inputs
        rst     = 1'b1;
        host_rx = 1'b0;
        tgt_rx  = 4'h0;
        auto_en = 1'b0;
        man_sel = 2'd2;
        step();
        step();
        check("rst_host_tx", host_tx, 1'b1);
        check("rst_tgt_tx", tgt_tx, 4'hF);
        check("rst_grant", grant, 2'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_led_hb", led_hb, 1'b0);

        host_rx = 1'b1;
        tgt_rx  = 4'hF;
        auto_en = 1'b1;
        man_sel = 2'd0;
        step();
        rst = 1'b0;
        step();
        step();
        check("idle_busy", busy, 1'b0);
        check("idle_host_tx", host_tx, 1'b1);

        // Frame 0x55 from target 2, 8 clk per bit, LSB first
        frame = 8'h55;
        hist_reset();
        for (int i = 0; i < 140; i++) begin
            b = i / 8;
            t = 4'hF;
            if (b == 0) t[2] = 1'b0;
            else if (b <= 8) t[2] = frame[b-1];
            act_on = (i >= 2 && i <= 136);
            lock_step(t, 1'b1, act_on, act_on, 2'd2, (i >= 2), "frame55");
        end

        // Host start, round-robin collisions, simultaneous host+target, all four
        for (int k = 0; k < 5; k++) begin
            run_vec(tbl[k]);
        end

        // Lock on target 1 while target 0 toggles
        hist_reset();
        for (int i = 0; i < 77; i++) begin
            t    = 4'hF;
            t[1] = (i < 8) ? 1'b0 : 1'b1;
            t[0] = (i >= 4 && i < 60 && ((i / 3) % 2 == 1)) ? 1'b0 : 1'b1;
            act_on = (i >= 2 && i <= 72);
            lock_step(t, 1'b1, act_on, act_on, 2'd1, (i >= 2), "lock_t1");
        end

        // Reset in the middle of a target 3 frame
        tgt_rx = 4'b0111;
        step();
        step();
        step();
        check("mid_grant", grant, 2'd3);
        check("mid_busy", busy, 1'b1);
        check("mid_host_tx", host_tx, 1'b0);
        rst = 1'b1;
        step();
        check("midrst_host_tx", host_tx, 1'b1);
        check("midrst_tgt_tx", tgt_tx, 4'hF);
        check("midrst_busy", busy, 1'b0);
        check("midrst_grant", grant, 2'd0);
        auto_en = 1'b0;
        man_sel = 2'd3;
        tgt_rx  = 4'hF;
        step();
        rst = 1'b0;
        step();
        step();
        check("man_grant", grant, 2'd3);
        check("man_busy", busy, 1'b0);

        // Manual: man_sel changes mid-frame, switch waits for 64 idle cycles
        hist_reset();
        for (int i = 0; i < 81; i++) begin
            t    = 4'hF;
            t[3] = (i < 8) ? 1'b0 : 1'b1;
            if (i == 3) man_sel = 2'd1;
            lock_step(t, 1'b1, 1'b1, 1'b0, (i <= 73) ? 2'd3 : 2'd1, 1'b1, "manual");
        end

        // Back to auto; host start should reuse the manual grant
        auto_en = 1'b1;
        repeat (70) step();
        check("auto_back_busy", busy, 1'b0);
        run_vec('{name: "man_to_auto", tgt_lo: 4'b0000, host_lo: 1'b1, exp_grant: 2'd1});

        // Heartbeat period
        prev = led_hb;
        cnt  = 0;
        while (led_hb == prev && cnt < 9000) begin
            step();
            cnt++;
        end
        check("hb_first_toggle_seen", (cnt < 9000), 1'b1);
        for (int r = 0; r < 2; r++) begin
            prev = led_hb;
            cnt  = 0;
            while (led_hb == prev && cnt < 5000) begin
                step();
                cnt++;
            end
            check("hb_period", cnt, 4096);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_port_arbiter.md
Name: uart_port_arbiter

Overview:
- Shares one host UART link among four target UART ports. Replaces pin-selected static routing with an activity-driven arbiter.
- In auto mode, the first port to show a start bit wins the link. The link stays locked until both directions have been idle for IDLE_CYCLES. Round-robin applies on simultaneous requests.
- In manual mode, it routes per man_sel. Selection changes are applied only on an idle link.
- Sits directly between the tile io pins and the UART lines.

Parameters:
- IDLE_CYCLES, 64: consecutive idle (both routed lines high) clk cycles that release the lock or allow a manual switch.
- HB_BIT, 12: heartbeat counter bit driven to led_hb. The counter is HB_BIT+1 bits wide.

Ports:
- clk  input  1  system clock (io_in[0])
- rst  input  1  synchronous, active-high reset
- host_rx  input  1  serial data from host
- tgt_rx  input  4  serial data from targets 0..3
- auto_en  input  1  1 = activity arbitration, 0 = manual selection
- man_sel  input  2  manual target index
- host_tx  output  1  serial data to host
- tgt_tx  output  4  serial data to targets 0..3
- grant  output  2  currently routed target index
- busy  output  1  link locked (LOCK state)
- led_hb  output  1  heartbeat blink

Behaviour:
- **Reset** (rst high at a clk edge):
  - state=IDLE, grant=0, last_grant=3, idle_cnt=0, heartbeat=0.
  - host_tx=1, tgt_tx=4'hF, busy=0, led_hb=0.
  - All synchronizer flops=1 (idle line).
  - Reset mid-frame aborts the frame and drives all lines idle on the next edge.
- **Synchronization:** every rx input passes through a 2-flop synchronizer; s_host and s_tgt[3:0] denote the synchronizer outputs.
- **Routing:**
  - Routing is registered. host_tx <= s_tgt[grant]; tgt_tx[grant] <= s_host; non-granted tgt_tx <= 1.
  - In IDLE, host_tx <= 1 and all tgt_tx <= 1, except on the grant edge.
  - Fixed data latency is 3 clk edges from pin to output; no bit is truncated.
- **idle_cnt:**
  - Saturates at IDLE_CYCLES; width clog2(IDLE_CYCLES+1).
  - Cleared when s_host==0 or s_tgt[grant]==0; otherwise increments.
  - Only these two lines count; other targets' activity is ignored.
- **State IDLE** (auto_en=1):
  - Winner = first i with s_tgt[i]==0, searching last_grant+1, +2, +3, +4 (mod 4).
  - If a winner exists: grant<=winner, last_grant<=winner, routing loads the same edge (start bit forwarded), idle_cnt<=0, state<=LOCK.
  - Else if s_host==0: grant<=last_grant, routing loads, state<=LOCK.
  - Target request beats a simultaneous host start.
- **State IDLE**, auto_en=0: grant<=man_sel, state<=MANUAL, idle_cnt<=IDLE_CYCLES.
- **State LOCK:**
  - busy=1; routes continuously.
  - When idle_cnt reaches IDLE_CYCLES-1 and both lines are high: state<=IDLE on that edge.
  - Changes to auto_en or man_sel are ignored while in LOCK.
- **State MANUAL:**
  - Routes continuously; busy=0.
  - If man_sel != grant and idle_cnt==IDLE_CYCLES: grant<=man_sel, idle_cnt<=0.
  - If auto_en=1 and idle_cnt==IDLE_CYCLES: state<=IDLE, last_grant<=grant.
  - Otherwise the current grant and state are held.
- **Heartbeat:** free-running counter, wraps; led_hb = counter[HB_BIT], registered.
- **Illegal states:** any illegal state encoding returns to IDLE on the next edge.

Test Plan:
1. **Reset:** rst=1 for 2 cycles with arbitrary inputs -> host_tx=1, tgt_tx=4'hF, grant=0, busy=0, led_hb=0.
2. **Auto grant/release:** auto_en=1; drive tgt_rx[2] frame 0x55 at 8 clk/bit.
   - host_tx reproduces the frame delayed exactly 3 clk.
   - grant=2, busy=1 from the edge the start bit is seen.
   - busy falls 64 cycles after the last low bit.
   - tgt_tx[0,1,3] stay 1 throughout.
3. **Round-robin collision:** last_grant=2; tgt_rx[0] and tgt_rx[3] fall on the same cycle -> grant=3.
   - After release, repeat the collision -> grant=0.
4. **Host-initiated:** after case 2, host_rx sends 0xA3 -> grant=2 (last_grant), tgt_tx[2] carries the frame +3 clk.
   - A simultaneous tgt_rx[1] start instead yields grant=1.
5. **Lock protection:** during LOCK on target 1, tgt_rx[0] toggles -> grant stays 1 and host_tx is unaffected.
   - idle_cnt is not cleared by target 0.
6. **Manual mode:**
   - auto_en=0, man_sel=3 -> grant=3 after IDLE.
   - Change man_sel=1 mid-frame -> grant stays 3 until 64 idle cycles, then becomes 1.
   - Heartbeat check: led_hb toggles every 4096 clk.
